sseg_hexdec_display: RTL and testbench

SSEG_HEXDEC_DISPLAY -- requirements
Module: sseg_hexdec_display

---
 rtl/sseg_pkg.sv | 46 ++++
 rtl/sseg_debounce.sv | 51 +++++
 rtl/sseg_hexdec_display.sv | 208 ++++++++++++++++++++
 tb/tb_sseg_hexdec_display.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sseg_pkg : segment code table, FSM state type and double-dabble helper
// Revision : 1.0
// ---------------------------------------------------------------------------
package sseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_UPDATE  = 2'd2
  } state_t;

  localparam logic [6:0] c_seg_dash  = 7'h3F;
  localparam logic [6:0] c_seg_blank = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h40;
      4'h1: code = 7'h79;
      4'h2: code = 7'h24;
      4'h3: code = 7'h30;
      4'h4: code = 7'h19;
      4'h5: code = 7'h12;
      4'h6: code = 7'h02;
      4'h7: code = 7'h78;
      4'h8: code = 7'h00;
      4'h9: code = 7'h10;
      4'hA: code = 7'h08;
      4'hB: code = 7'h03;
      4'hC: code = 7'h46;
      4'hD: code = 7'h21;
      4'hE: code = 7'h06;
      default: code = 7'h0E;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] dd_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sseg_debounce : two-flop synchroniser, counter debouncer, rising-edge pulse
// Revision : 1.0
// ---------------------------------------------------------------------------
module sseg_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_rise;
  logic [c_cnt_w-1:0] r_cnt;

  // A sample equal to the current level restarts the run of differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/sseg_hexdec_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sseg_hexdec_display : multiplexed 7-seg display, hex or BCD with button mode
// Revision : 1.0
// ---------------------------------------------------------------------------
module sseg_hexdec_display
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DATA_W          = 14,
  parameter int REFRESH_CYCLES  = 50000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn,
  input  logic [DATA_W-1:0]     value,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic [6:0]            sseg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic                  mode_dec
);

  localparam int c_bcd_w = 4 * NUM_DIGITS;
  localparam int c_bit_w = $clog2(DATA_W + 1);
  localparam int c_ref_w = $clog2(REFRESH_CYCLES + 1);
  localparam int c_idx_w = $clog2(NUM_DIGITS);
  localparam logic [63:0]        c_dec_limit = 64'(10 ** NUM_DIGITS);
  localparam logic [c_bit_w-1:0] c_bit_last  = c_bit_w'(DATA_W - 1);
  localparam logic [c_ref_w-1:0] c_ref_last  = c_ref_w'(REFRESH_CYCLES - 1);
  localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(NUM_DIGITS - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_accept;
  logic                 w_load_disp;

  logic [DATA_W-1:0]    r_shift;
  logic [c_bcd_w-1:0]   r_bcd;
  logic [c_bit_w-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]    r_cap_value;
  logic                 r_cap_ovf;
  logic [c_bcd_w-1:0]   w_bcd_adj;
  logic [c_bcd_w-1:0]   w_bcd_next;

  logic [c_bcd_w-1:0]   r_disp_bcd;
  logic [DATA_W-1:0]    r_disp_value;
  logic                 r_disp_ovf;
  logic [c_bcd_w-1:0]   w_hex_view;
  logic                 w_trunc;
  logic [NUM_DIGITS-1:0] w_blank;
  logic                 w_seen;

  logic [c_ref_w-1:0]   r_refresh_cnt;
  logic [c_idx_w-1:0]   r_digit_idx;
  logic [c_idx_w-1:0]   w_next_idx;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]           r_sseg;
  logic                 r_dp;
  logic [6:0]           w_seg_next;
  logic                 w_dp_next;
  logic [3:0]           w_hex_nib;
  logic [3:0]           w_dec_nib;

  logic                 r_mode_dec;
  logic                 w_rise;

  sseg_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn),
    .rise (w_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    value_ready  = 1'b0;
    w_accept     = 1'b0;
    w_load_disp  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        value_ready = 1'b1;
        if (value_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (r_bit_cnt == c_bit_last) w_state_next = ST_UPDATE;
      end
      ST_UPDATE: begin
        w_load_disp  = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dd
    assign w_bcd_adj[4*g +: 4] = dd_adjust(r_bcd[4*g +: 4]);
  end
  // Overflowing values lose their top carry; they are shown as dashes anyway
  assign w_bcd_next = c_bcd_w'({w_bcd_adj, r_shift[DATA_W-1]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_bcd        <= '0;
      r_bit_cnt    <= '0;
      r_cap_value  <= '0;
      r_cap_ovf    <= 1'b0;
      r_disp_bcd   <= '0;
      r_disp_value <= '0;
      r_disp_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift     <= value;
        r_cap_value <= value;
        r_cap_ovf   <= (64'(value) >= c_dec_limit);
        r_bcd       <= '0;
        r_bit_cnt   <= '0;
      end else if (r_state == ST_CONVERT) begin
        r_shift   <= r_shift << 1;
        r_bcd     <= w_bcd_next;
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_load_disp) begin
        r_disp_bcd   <= r_bcd;
        r_disp_value <= r_cap_value;
        r_disp_ovf   <= r_cap_ovf;
      end
    end
  end

  if (DATA_W > c_bcd_w) begin : g_trunc
    assign w_hex_view = r_disp_value[c_bcd_w-1:0];
    assign w_trunc    = |r_disp_value[DATA_W-1:c_bcd_w];
  end else if (DATA_W == c_bcd_w) begin : g_exact
    assign w_hex_view = r_disp_value;
    assign w_trunc    = 1'b0;
  end else begin : g_pad
    assign w_hex_view = {{(c_bcd_w - DATA_W){1'b0}}, r_disp_value};
    assign w_trunc    = 1'b0;
  end

  // A digit is a leading zero when it and every digit to its left are zero
  always_comb begin
    w_seen  = 1'b0;
    w_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (r_disp_bcd[4*k +: 4] != 4'd0) w_seen = 1'b1;
      w_blank[k] = !w_seen && (k != 0);
    end
  end

  assign w_next_idx = (r_digit_idx == c_idx_last) ? '0 : r_digit_idx + 1'b1;
  assign w_hex_nib  = w_hex_view[4*w_next_idx +: 4];
  assign w_dec_nib  = r_disp_bcd[4*w_next_idx +: 4];

  always_comb begin
    w_seg_next = c_seg_blank;
    if (!r_mode_dec)              w_seg_next = seg_code(w_hex_nib);
    else if (r_disp_ovf)          w_seg_next = c_seg_dash;
    else if (w_blank[w_next_idx]) w_seg_next = c_seg_blank;
    else                          w_seg_next = seg_code(w_dec_nib);
  end

  assign w_dp_next = !(!r_mode_dec && w_trunc && (w_next_idx == c_idx_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= '0;
      r_an          <= '1;
      r_sseg        <= c_seg_blank;
      r_dp          <= 1'b1;
    end else if (r_refresh_cnt == c_ref_last) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= w_next_idx;
      r_an          <= ~(NUM_DIGITS'(1) << w_next_idx);
      r_sseg        <= w_seg_next;
      r_dp          <= w_dp_next;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_mode_dec <= 1'b1;
    else if (w_rise) r_mode_dec <= ~r_mode_dec;
  end

  assign an       = r_an;
  assign sseg     = r_sseg;
  assign dp       = r_dp;
  assign mode_dec = r_mode_dec;

endmodule
`default_nettype wire

// File: tb/tb_sseg_hexdec_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sseg_hexdec_display : directed self-checking bench for the display block
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_sseg_hexdec_display;

  logic        clk;
  logic        rst_n;
  logic        btn;
  logic [13:0] value;
  logic        value_valid;
  logic        value_ready;
  logic [6:0]  sseg;
  logic [3:0]  an;
  logic        dp;
  logic        mode_dec;

  int err_cnt = 0;
  int chk_cnt = 0;

  sseg_hexdec_display #(
    .NUM_DIGITS     (4),
    .DATA_W         (14),
    .REFRESH_CYCLES (4),
    .DEBOUNCE_CYCLES(8)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .value      (value),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .sseg       (sseg),
    .an         (an),
    .dp         (dp),
    .mode_dec   (mode_dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [13:0] v);
    @(negedge clk);
    value       = v;
    value_valid = 1'b1;
    @(posedge clk);
    #1 value_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (value_ready) break;
      n++;
    end
    check(tag, n, 15);
  endtask

  // Waits for a fresh digit-0 slot, then walks all four slots
  task automatic scan(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                      input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    int n;
    exp_seg = '{e0, e1, e2, e3};
    n = 0;
    while (an == 4'b1110 && n < 64) begin @(negedge clk); n++; end
    while (an != 4'b1110 && n < 64) begin @(negedge clk); n++; end
    check($sformatf("%s_sync", tag), 32'(n < 64), 1);
    for (int k = 0; k < 4; k++) begin
      exp_an = ~(4'b0001 << k);
      check($sformatf("%s_an%0d", tag, k), an, exp_an);
      check($sformatf("%s_seg%0d", tag, k), sseg, exp_seg[k]);
      check($sformatf("%s_dp%0d", tag, k), dp, 1);
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    btn         = 1'b0;
    value       = '0;
    value_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'b1111);
    check("rst_sseg", sseg, 7'h7F);
    check("rst_dp", dp, 1);
    check("rst_mode", mode_dec, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", value_ready, 1);
    check("rel_an", an, 4'b1111);

    scan("init", 7'h40, 7'h7F, 7'h7F, 7'h7F);

    send(14'd1234);
    wait_ready("lat_1234");
    scan("d1234", 7'h19, 7'h30, 7'h24, 7'h79);

    send(14'd7);
    wait_ready("lat_7");
    scan("d7", 7'h78, 7'h7F, 7'h7F, 7'h7F);

    send(14'd10000);
    wait_ready("lat_ovf");
    scan("ovf", 7'h3F, 7'h3F, 7'h3F, 7'h3F);

    @(negedge clk);
    btn = 1'b1;
    repeat (14) @(negedge clk);
    check("mode_press", mode_dec, 0);
    btn = 1'b0;
    repeat (20) @(negedge clk);
    check("mode_release", mode_dec, 0);

    send(14'h2A3F);
    wait_ready("lat_hex");
    scan("hex", 7'h0E, 7'h30, 7'h08, 7'h24);

    repeat (5) begin
      btn = 1'b1;
      repeat (3) @(negedge clk);
      btn = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("mode_glitch", mode_dec, 0);

    send(14'd9999);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_an", an, 4'b1111);
    check("async_sseg", sseg, 7'h7F);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", value_ready, 1);
    check("abort_an", an, 4'b1111);
    check("abort_mode", mode_dec, 1);
    scan("abort", 7'h40, 7'h7F, 7'h7F, 7'h7F);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
